// File: rtl/gost89_pkg.sv
// Shared types and the GOST 28147-89 round function for the CFB streaming controller.
package gost89_pkg;

  typedef logic [63:0] gost_blk_t;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_IV,
    READY,
    LOAD,
    WAIT_HI,
    WAIT_DONE,
    DRAIN,
    ERROR
  } cfb_ctrl_state_t;

  localparam int GOST_KEY_W  = 256;
  localparam int GOST_SBOX_W = 512;

  // S-box j (64 bits, 16 nibbles) substitutes nibble j, then rotate left by 11.
  function automatic logic [31:0] gost_f(input logic [31:0] x, input logic [GOST_SBOX_W-1:0] sbox);
    logic [31:0] s;
    s = '0;
    for (int j = 0; j < 8; j++) begin
      s[4*j +: 4] = sbox[64*j + 4*int'(x[4*j +: 4]) +: 4];
    end
    return {s[20:0], s[31:21]};
  endfunction

endpackage

// File: rtl/gost89_blk_fifo2.sv
// Two-entry registered FIFO holding {last, data}; head entry drives the read port directly.
module gost89_blk_fifo2 (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        flush_i,
  input  logic        push_i,
  input  logic        pop_i,
  input  logic [64:0] wdata_i,
  output logic [64:0] rdata_o,
  output logic        full_o,
  output logic        empty_o,
  output logic [1:0]  count_o
);

  logic [64:0] head_q, head_d, tail_q, tail_d;
  logic [1:0]  cnt_q, cnt_d;

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    if (flush_i) begin
      cnt_d = 2'd0;
    end else begin
      case ({push_i, pop_i})
        2'b10: begin
          if (cnt_q == 2'd0) head_d = wdata_i;
          else               tail_d = wdata_i;
          cnt_d = cnt_q + 2'd1;
        end
        2'b01: begin
          head_d = tail_q;
          cnt_d  = cnt_q - 2'd1;
        end
        2'b11: begin
          if (cnt_q == 2'd2) begin
            head_d = tail_q;
            tail_d = wdata_i;
          end else begin
            head_d = wdata_i;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= 2'd0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  assign rdata_o = head_q;
  assign full_o  = (cnt_q == 2'd2);
  assign empty_o = (cnt_q == 2'd0);
  assign count_o = cnt_q;

endmodule

// File: rtl/gost89_cfb.sv
// GOST 28147-89 CFB core, one round per clock. reset && !load_data loads the gamma from in;
// load_data starts a 32-round gamma encryption, out = in ^ E(gamma) when busy falls.
module gost89_cfb
  import gost89_pkg::*;
(
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   mode_i,
  input  logic                   load_data_i,
  input  logic [GOST_SBOX_W-1:0] sbox_i,
  input  logic [GOST_KEY_W-1:0]  key_i,
  input  gost_blk_t              in_i,
  output gost_blk_t              out_o,
  output logic                   busy_o
);

  gost_blk_t   gamma_q, data_q;
  logic [31:0] n1_q, n2_q, n1_d;
  logic [4:0]  rnd_q;
  logic [2:0]  kidx;

  // Key words run K0..K7 three times, then K7..K0.
  always_comb begin
    kidx = (rnd_q < 5'd24) ? rnd_q[2:0] : ~rnd_q[2:0];
    n1_d = n2_q ^ gost_f(n1_q + key_i[32*int'(kidx) +: 32], sbox_i);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      busy_o <= 1'b0;
      if (!load_data_i) gamma_q <= in_i;
    end else if (load_data_i) begin
      data_q <= in_i;
      n1_q   <= gamma_q[31:0];
      n2_q   <= gamma_q[63:32];
      rnd_q  <= 5'd0;
      busy_o <= 1'b1;
    end else if (busy_o) begin
      n1_q  <= n1_d;
      n2_q  <= n1_q;
      rnd_q <= rnd_q + 5'd1;
      if (rnd_q == 5'd31) begin
        busy_o  <= 1'b0;
        out_o   <= data_q ^ {n1_d, n1_q};
        gamma_q <= mode_i ? data_q : (data_q ^ {n1_d, n1_q});
      end
    end
  end

endmodule

// File: rtl/gost89_cfb_stream_ctrl.sv
// Streams a multi-block message through one gost89_cfb core with a 2-entry result FIFO.
//   state     | meaning
//   IDLE      | no session, core held in reset
//   LOAD_IV   | core latches the session IV as gamma
//   READY     | accept next block when a FIFO slot is guaranteed
//   LOAD      | pulse load_data with the latched block
//   WAIT_HI   | wait for core busy to rise
//   WAIT_DONE | wait for busy to fall, then push result
//   DRAIN     | last block done, wait for FIFO to empty
//   ERROR     | core timed out, held until start or abort
module gost89_cfb_stream_ctrl
  import gost89_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   start_i,
  input  logic                   abort_i,
  input  logic                   mode_i,
  input  logic [GOST_KEY_W-1:0]  key_i,
  input  logic [GOST_SBOX_W-1:0] sbox_i,
  input  gost_blk_t              iv_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  gost_blk_t              in_data_i,
  input  logic                   in_last_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output gost_blk_t              out_data_o,
  output logic                   out_last_o,
  output logic                   active_o,
  output logic                   error_o,
  output logic [CNT_W-1:0]       blk_cnt_o
);

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES);

  cfb_ctrl_state_t        state_q;
  logic                   mode_q, last_q, error_q;
  logic [GOST_KEY_W-1:0]  key_q;
  logic [GOST_SBOX_W-1:0] sbox_q;
  gost_blk_t              iv_q, blk_q, core_in, core_out;
  logic [TMO_W-1:0]       tmo_q;
  logic [CNT_W-1:0]       blk_cnt_q;
  logic                   core_rst, core_load, core_busy, blk_done;
  logic                   fifo_full, fifo_empty;
  logic [1:0]             fifo_cnt;
  logic [64:0]            fifo_rdata;

  assign core_rst  = (state_q == IDLE) || (state_q == LOAD_IV) || (state_q == ERROR);
  assign core_load = (state_q == LOAD);
  assign core_in   = core_load ? blk_q : iv_q;
  assign blk_done  = (state_q == WAIT_DONE) && !core_busy;

  // Gating on !full while READY guarantees a free slot for the block about to be loaded.
  assign in_ready_o  = (state_q == READY) && !fifo_full;
  assign out_valid_o = !fifo_empty;
  assign out_data_o  = fifo_rdata[63:0];
  assign out_last_o  = fifo_rdata[64];
  assign active_o    = (state_q != IDLE) && (state_q != ERROR);
  assign error_o     = error_q;
  assign blk_cnt_o   = blk_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      mode_q    <= 1'b0;
      key_q     <= '0;
      sbox_q    <= '0;
      iv_q      <= '0;
      blk_q     <= '0;
      last_q    <= 1'b0;
      tmo_q     <= '0;
      error_q   <= 1'b0;
      blk_cnt_q <= '0;
    end else if (abort_i) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE, ERROR: begin
          if (start_i) begin
            mode_q    <= mode_i;
            key_q     <= key_i;
            sbox_q    <= sbox_i;
            iv_q      <= iv_i;
            last_q    <= 1'b0;
            error_q   <= 1'b0;
            blk_cnt_q <= '0;
            state_q   <= LOAD_IV;
          end
        end
        LOAD_IV: state_q <= READY;
        READY: begin
          if (in_valid_i && in_ready_o) begin
            blk_q   <= in_data_i;
            last_q  <= in_last_i;
            state_q <= LOAD;
          end
        end
        LOAD: begin
          tmo_q   <= TMO_W'(TIMEOUT_CYCLES - 2);
          state_q <= WAIT_HI;
        end
        WAIT_HI, WAIT_DONE: begin
          if (blk_done) begin
            blk_cnt_q <= blk_cnt_q + CNT_W'(1);
            state_q   <= last_q ? DRAIN : READY;
          end else if (tmo_q == '0) begin
            error_q <= 1'b1;
            state_q <= ERROR;
          end else begin
            tmo_q <= tmo_q - TMO_W'(1);
            if (state_q == WAIT_HI && core_busy) state_q <= WAIT_DONE;
          end
        end
        DRAIN: if (fifo_cnt == 2'd0) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  gost89_cfb u_core (
    .clk_i       (clk_i),
    .reset_i     (core_rst),
    .mode_i      (mode_q),
    .load_data_i (core_load),
    .sbox_i      (sbox_q),
    .key_i       (key_q),
    .in_i        (core_in),
    .out_o       (core_out),
    .busy_o      (core_busy)
  );

  gost89_blk_fifo2 u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (abort_i),
    .push_i  (blk_done && !abort_i),
    .pop_i   (out_valid_o && out_ready_i),
    .wdata_i ({last_q, core_out}),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt)
  );

endmodule
